// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared light codes, approach indices, scheduler state encoding and the per-approach light decode.
package traffic_pkg;

   localparam logic [1:0] LIGHT_RED    = 2'b00;
   localparam logic [1:0] LIGHT_GREEN  = 2'b01;
   localparam logic [1:0] LIGHT_YELLOW = 2'b10;

   localparam logic [1:0] DIR_N = 2'd0;
   localparam logic [1:0] DIR_E = 2'd1;
   localparam logic [1:0] DIR_S = 2'd2;
   localparam logic [1:0] DIR_W = 2'd3;

   typedef enum logic [1:0] {IDLE, GREEN, YELLOW, ALL_RED} state_t;

   function automatic logic [3:0] dir_onehot(input logic [1:0] d);
      return 4'b0001 << d;
   endfunction

   // Only the served approach can be non-red; every other approach is red in all states.
   function automatic logic [1:0] light_code(input state_t s, input logic [1:0] cur,
                                              input logic [1:0] d);
      logic [1:0] code;
      code = LIGHT_RED;
      if (cur == d) begin
         if (s == GREEN)       code = LIGHT_GREEN;
         else if (s == YELLOW) code = LIGHT_YELLOW;
      end
      return code;
   endfunction

endpackage

// File: rtl/traffic_phase_scheduler_arb.sv
// Combinational 4-way round-robin select: first set call at or after ptr, wrapping N->E->S->W.
module rr_arbiter4
   import traffic_pkg::*;
(
   input  logic [3:0] eff,
   input  logic [1:0] ptr,
   output logic [1:0] winner,
   output logic       any
);

   // Scan from farthest to nearest offset so the closest set bit to ptr is written last.
   always_comb begin
      winner = DIR_N;
      any    = |eff;
      for (int i = 3; i >= 0; i--) begin
         if (eff[ptr + 2'(i)]) winner = ptr + 2'(i);
      end
   end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated 4-approach phase scheduler: call latch, round-robin grant, green/yellow/all-red sequencing.
module traffic_phase_scheduler
   import traffic_pkg::*;
#(
   parameter int MIN_GREEN = 4,
   parameter int MAX_GREEN = 10,
   parameter int YELLOW    = 2,
   parameter int ALL_RED   = 1
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   output logic [1:0] NS_light,
   output logic [1:0] EW_light,
   output logic [1:0] SN_light,
   output logic [1:0] WE_light,
   output logic       grant_valid,
   output logic [1:0] grant_dir,
   output logic [3:0] pending
);

   localparam int TW      = $clog2(MAX_GREEN + 1);
   localparam int CLR_MAX = (YELLOW > ALL_RED) ? YELLOW : ALL_RED;
   localparam int CW      = $clog2(CLR_MAX + 1);

   state_t          r_state;
   logic [TW-1:0]   r_timer;
   logic [CW-1:0]   r_clr;
   logic [1:0]      r_ptr;
   logic [1:0]      r_cur;
   logic [3:0]      r_pending;

   logic [3:0]      w_eff;
   logic [3:0]      w_cur_oh;
   logic            w_others;
   logic [1:0]      w_arb_ptr;
   logic [1:0]      w_win;
   logic            w_any;
   logic [TW:0]     w_n;
   logic            w_green_exit;
   logic            w_yel_done;
   logic            w_red_done;
   logic            w_enter_green;
   logic [3:0]      w_set;
   logic [3:0]      w_pend_nxt;

   assign w_eff    = r_pending | req;
   assign w_cur_oh = dir_onehot(r_cur);
   assign w_others = |(w_eff & ~w_cur_oh);

   // At all-red exit the pointer advances this very edge, so the arbiter must already see cur+1.
   assign w_arb_ptr = (r_state == traffic_pkg::ALL_RED) ? (r_cur + 2'd1) : r_ptr;

   rr_arbiter4 u_arb (
      .eff    (w_eff),
      .ptr    (w_arb_ptr),
      .winner (w_win),
      .any    (w_any)
   );

   assign w_n          = (TW+1)'(r_timer) + (TW+1)'(1);
   assign w_green_exit = (r_state == traffic_pkg::GREEN) &&
                         ((w_n == (TW+1)'(MAX_GREEN)) ||
                          ((w_n >= (TW+1)'(MIN_GREEN)) && (!req[r_cur] || w_others)));
   assign w_yel_done   = (r_clr == CW'(YELLOW - 1));
   assign w_red_done   = (r_clr == CW'(ALL_RED - 1));
   assign w_enter_green = w_any && ((r_state == traffic_pkg::IDLE) ||
                                    ((r_state == traffic_pkg::ALL_RED) && w_red_done));

   // A call for the approach being served is not latched; the entry clear beats a same-cycle set.
   assign w_set      = (r_state == traffic_pkg::GREEN) ? (req & ~w_cur_oh) : req;
   assign w_pend_nxt = (r_pending | w_set) & ~(w_enter_green ? dir_onehot(w_win) : 4'b0000);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= traffic_pkg::IDLE;
         r_timer   <= '0;
         r_clr     <= '0;
         r_ptr     <= DIR_N;
         r_cur     <= DIR_N;
         r_pending <= 4'b0000;
      end else begin
         r_pending <= w_pend_nxt;
         case (r_state)
            traffic_pkg::IDLE: begin
               if (w_any) begin
                  r_state <= traffic_pkg::GREEN;
                  r_cur   <= w_win;
                  r_timer <= '0;
               end
            end
            traffic_pkg::GREEN: begin
               if (w_green_exit) begin
                  r_state <= traffic_pkg::YELLOW;
                  r_timer <= '0;
                  r_clr   <= '0;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            traffic_pkg::YELLOW: begin
               if (w_yel_done) begin
                  r_state <= traffic_pkg::ALL_RED;
                  r_clr   <= '0;
               end else begin
                  r_clr <= r_clr + CW'(1);
               end
            end
            traffic_pkg::ALL_RED: begin
               if (w_red_done) begin
                  r_ptr <= r_cur + 2'd1;
                  r_clr <= '0;
                  if (w_any) begin
                     r_state <= traffic_pkg::GREEN;
                     r_cur   <= w_win;
                     r_timer <= '0;
                  end else begin
                     r_state <= traffic_pkg::IDLE;
                  end
               end else begin
                  r_clr <= r_clr + CW'(1);
               end
            end
            default: r_state <= traffic_pkg::IDLE;
         endcase
      end
   end

   assign NS_light    = light_code(r_state, r_cur, DIR_N);
   assign EW_light    = light_code(r_state, r_cur, DIR_E);
   assign SN_light    = light_code(r_state, r_cur, DIR_S);
   assign WE_light    = light_code(r_state, r_cur, DIR_W);
   assign grant_valid = (r_state == traffic_pkg::GREEN) || (r_state == traffic_pkg::YELLOW);
   assign grant_dir   = grant_valid ? r_cur : DIR_N;
   assign pending     = r_pending;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Cycle-by-cycle bench: per-cycle {inputs, expected outputs} records checked through an expectation queue.
module tb_traffic_phase_scheduler;
   import traffic_pkg::*;

   localparam int K_RED = 0;
   localparam int K_GRN = 1;
   localparam int K_YEL = 2;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [7:0] lights;
      logic       gv;
      logic [1:0] gd;
      logic [3:0] pend;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic [1:0] NS_light, EW_light, SN_light, WE_light;
   logic       grant_valid;
   logic [1:0] grant_dir;
   logic [3:0] pending;

   vec_t  tbl[$];
   vec_t  exp_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   int    step  = 0;
   string tag;

   traffic_phase_scheduler dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .NS_light    (NS_light),
      .EW_light    (EW_light),
      .SN_light    (SN_light),
      .WE_light    (WE_light),
      .grant_valid (grant_valid),
      .grant_dir   (grant_dir),
      .pending     (pending)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic rst, input logic [3:0] rq, input int kind,
                               input logic [1:0] dir, input logic [3:0] pend);
      vec_t       v;
      logic [1:0] code;
      code     = (kind == K_GRN) ? LIGHT_GREEN : (kind == K_YEL) ? LIGHT_YELLOW : LIGHT_RED;
      v.rst    = rst;
      v.req    = rq;
      v.lights = 8'(code) << (2 * int'(dir));
      v.gv     = (kind != K_RED);
      v.gd     = dir;
      v.pend   = pend;
      return v;
   endfunction

   task automatic add(input logic rst, input logic [3:0] rq, input int kind,
                      input logic [1:0] dir, input logic [3:0] pend, input int n);
      repeat (n) tbl.push_back(mk(rst, rq, kind, dir, pend));
   endtask

   task automatic check();
      vec_t       e;
      logic [7:0] act;
      e   = exp_q.pop_front();
      act = {WE_light, SN_light, EW_light, NS_light};
      n_cmp++;
      if (act !== e.lights || grant_valid !== e.gv || pending !== e.pend ||
          (e.gv && grant_dir !== e.gd)) begin
         n_bad++;
         $display("FAIL %s step %0d: got lights=%b gv=%b dir=%0d pend=%b, expected lights=%b gv=%b dir=%0d pend=%b",
                  tag, step, act, grant_valid, grant_dir, pending, e.lights, e.gv, e.gd, e.pend);
      end
   endtask

   // Drive at the falling edge, let one rising edge act, sample at the next falling edge.
   task automatic cyc(input vec_t v);
      reset = v.rst;
      req   = v.req;
      exp_q.push_back(v);
      @(negedge clk);
      check();
      step++;
   endtask

   task automatic run(input logic rst, input logic [3:0] rq, input int kind,
                      input logic [1:0] dir, input logic [3:0] pend);
      cyc(mk(rst, rq, kind, dir, pend));
   endtask

   task automatic run_tbl(input string name);
      tag  = name;
      step = 0;
      for (int i = 0; i < tbl.size(); i++) cyc(tbl[i]);
      tbl.delete();
   endtask

   initial begin
      reset = 1'b1;
      req   = 4'b0000;
      @(negedge clk);

      add(1, 4'b0000, K_RED, DIR_N, 4'b0000, 1);
      add(0, 4'b0000, K_RED, DIR_N, 4'b0000, 20);
      run_tbl("reset_idle");

      add(0, 4'b0001, K_GRN, DIR_N, 4'b0000, 1);
      add(0, 4'b0000, K_GRN, DIR_N, 4'b0000, 3);
      add(0, 4'b0000, K_YEL, DIR_N, 4'b0000, 2);
      add(0, 4'b0000, K_RED, DIR_N, 4'b0000, 4);
      run_tbl("pulse_n");

      // Held call: max-out, call re-latched during yellow, then re-granted to N.
      add(0, 4'b0001, K_GRN, DIR_N, 4'b0000, 10);
      add(0, 4'b0001, K_YEL, DIR_N, 4'b0000, 1);
      add(0, 4'b0001, K_YEL, DIR_N, 4'b0001, 1);
      add(0, 4'b0001, K_RED, DIR_N, 4'b0001, 1);
      add(0, 4'b0001, K_GRN, DIR_N, 4'b0000, 1);
      add(0, 4'b0000, K_GRN, DIR_N, 4'b0000, 3);
      add(0, 4'b0000, K_YEL, DIR_N, 4'b0000, 2);
      add(0, 4'b0000, K_RED, DIR_N, 4'b0000, 3);
      run_tbl("maxout_regrant");

      add(1, 4'b0000, K_RED, DIR_N, 4'b0000, 1);
      add(0, 4'b1111, K_GRN, DIR_N, 4'b1110, 1);
      add(0, 4'b0000, K_GRN, DIR_N, 4'b1110, 3);
      add(0, 4'b0000, K_YEL, DIR_N, 4'b1110, 2);
      add(0, 4'b0000, K_RED, DIR_N, 4'b1110, 1);
      add(0, 4'b0000, K_GRN, DIR_E, 4'b1100, 4);
      add(0, 4'b0000, K_YEL, DIR_E, 4'b1100, 2);
      add(0, 4'b0000, K_RED, DIR_N, 4'b1100, 1);
      add(0, 4'b0000, K_GRN, DIR_S, 4'b1000, 4);
      add(0, 4'b0000, K_YEL, DIR_S, 4'b1000, 2);
      add(0, 4'b0000, K_RED, DIR_N, 4'b1000, 1);
      add(0, 4'b0000, K_GRN, DIR_W, 4'b0000, 4);
      add(0, 4'b0000, K_YEL, DIR_W, 4'b0000, 2);
      add(0, 4'b0000, K_RED, DIR_N, 4'b0000, 3);
      run_tbl("all_four");

      // E held, N pulsed in E green cycle 2: E yields at 4, N found by wrap from pointer 2.
      tag  = "yield_wrap";
      step = 0;
      run(0, 4'b0010, K_GRN, DIR_E, 4'b0000);
      run(0, 4'b0010, K_GRN, DIR_E, 4'b0000);
      run(0, 4'b0011, K_GRN, DIR_E, 4'b0001);
      run(0, 4'b0010, K_GRN, DIR_E, 4'b0001);
      run(0, 4'b0010, K_YEL, DIR_E, 4'b0001);
      run(0, 4'b0000, K_YEL, DIR_E, 4'b0001);
      run(0, 4'b0000, K_RED, DIR_N, 4'b0001);
      run(0, 4'b0000, K_GRN, DIR_N, 4'b0000);
      for (int i = 0; i < 3; i++) run(0, 4'b0000, K_GRN, DIR_N, 4'b0000);
      for (int i = 0; i < 2; i++) run(0, 4'b0000, K_YEL, DIR_N, 4'b0000);
      for (int i = 0; i < 3; i++) run(0, 4'b0000, K_RED, DIR_N, 4'b0000);

      // Pointer now at E; calls S,N,W pick S and leave N,W latched, then reset lands in S yellow.
      tag  = "reset_in_yellow";
      step = 0;
      run(0, 4'b1101, K_GRN, DIR_S, 4'b1001);
      for (int i = 0; i < 3; i++) run(0, 4'b0000, K_GRN, DIR_S, 4'b1001);
      run(0, 4'b0000, K_YEL, DIR_S, 4'b1001);
      run(1, 4'b0000, K_RED, DIR_N, 4'b0000);
      for (int i = 0; i < 15; i++) run(0, 4'b0000, K_RED, DIR_N, 4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
